cipher_stream_core: RTL and testbench

Parametrised streaming successor to the single-character subtraction cipher. It supports both encrypt, C = (P − K) mod MOD_P, and decrypt, P = (C + K) mod MOD_P. Characters enter and leave over valid/ready handshakes, with a registered key, a two-stage pipeline, an output FIFO and error/throughput counters. It sits between the character source (UART/message buffer) and the ciphertext sink.

---
 rtl/cipher_stream_core.sv | 174 +++++++++++++++++
 tb/tb_cipher_stream_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_stream_core.sv
// Streaming modular subtraction cipher: registered key, operand stage, result
// stage feeding a small output FIFO, with saturating ok/error pop counters.
module cipher_stream_core #(
   parameter int                DATA_W     = 8,
   parameter int                MOD_P      = 227,
   parameter logic [DATA_W-1:0] CHAR_LO    = 8'h61,
   parameter logic [DATA_W-1:0] CHAR_HI    = 8'h7A,
   parameter int                FIFO_DEPTH = 4,
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_load,
   input  logic [DATA_W-1:0] key_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [CNT_W-1:0]  ok_count,
   output logic [CNT_W-1:0]  err_count,
   input  logic              cnt_clr
);

   localparam int                PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int                CW      = PW + 1;
   localparam logic [DATA_W:0]   MOD_C   = (DATA_W+1)'(MOD_P);
   localparam logic [CW:0]       DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [1:0]        MODE_ENC = 2'b10;
   localparam logic [1:0]        MODE_DEC = 2'b01;

   function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic signed [DATA_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d < 0)
         d = d + $signed(MOD_C);
      return d[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= MOD_C)
         s = s - MOD_C;
      return s[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] key_reduce(input logic [DATA_W-1:0] k);
      // MOD_P exceeds half the key range, so one conditional subtract suffices.
      return ({1'b0, k} >= MOD_C) ? DATA_W'({1'b0, k} - MOD_C) : k;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   logic [DATA_W-1:0] k_red;
   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic [DATA_W-1:0] key_p1;
   logic [1:0]        mode_p1;
   logic              err_p2;
   logic [DATA_W-1:0] res_p2;
   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occ;
   logic [DATA_W:0]   head;
   logic              accept;
   logic              push;
   logic              pop;

   assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1};
   assign in_ready = (occ < DEPTH_C);
   assign accept   = in_valid & in_ready;
   assign push     = vld_p1;
   assign pop      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         k_red <= '0;
      else if (key_load)
         k_red <= key_reduce(key_in);
   end

   // ---- stage 1: operand capture ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= accept;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         data_p1 <= in_data;
         key_p1  <= k_red;
         mode_p1 <= in_mode;
      end
   end

   // ---- stage 2: legality check and modular arithmetic ----
   always_comb begin
      err_p2 = 1'b1;
      res_p2 = '0;
      case (mode_p1)
         MODE_ENC: begin
            if (data_p1 >= CHAR_LO && data_p1 <= CHAR_HI) begin
               err_p2 = 1'b0;
               res_p2 = mod_sub(data_p1, key_p1);
            end
         end
         MODE_DEC: begin
            if ({1'b0, data_p1} < MOD_C) begin
               err_p2 = 1'b0;
               res_p2 = mod_add(data_p1, key_p1);
            end
         end
         default: ;
      endcase
   end

   // ---- output FIFO ----
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {err_p2, res_p2};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign head      = mem[rd_ptr];
   assign out_valid = (fifo_count != '0);
   assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
   assign out_err   = out_valid & head[DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_count  <= '0;
         err_count <= '0;
      end else if (cnt_clr) begin
         ok_count  <= '0;
         err_count <= '0;
      end else if (pop) begin
         if (out_err)
            err_count <= sat_inc(err_count);
         else
            ok_count  <= sat_inc(ok_count);
      end
   end

endmodule

// File: tb/tb_cipher_stream_core.sv
// Randomised and directed bench for cipher_stream_core with a queue-based
// reference model of the cipher, FIFO ordering and the pop counters.
`timescale 1ns/1ps
module tb_cipher_stream_core;

   localparam int P    = 227;
   localparam int CMAX = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_load = 1'b0;
   logic [7:0] key_in = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_mode = 2'b10;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_err;
   logic [3:0] ok_count;
   logic [3:0] err_count;
   logic       cnt_clr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   cipher_stream_core #(
      .DATA_W(8), .MOD_P(227), .CHAR_LO(8'h61), .CHAR_HI(8'h7A),
      .FIFO_DEPTH(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .ok_count(ok_count), .err_count(err_count), .cnt_clr(cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference cipher: returns {err, result}.
   function automatic logic [8:0] ref_char(input logic [1:0] m, input int d, input int k);
      if (m == 2'b10 && d >= 'h61 && d <= 'h7A)
         return {1'b0, 8'((((d - k) % P) + P) % P)};
      if (m == 2'b01 && d < P)
         return {1'b0, 8'((d + k) % P)};
      return 9'h100;
   endfunction

   logic [8:0] exp_q[$];
   logic [8:0] exp_v;
   int m_key = 0;
   int m_ok  = 0;
   int m_err = 0;
   int acc_cnt = 0;

   // Scoreboard: samples one time unit before each rising edge.
   always @(negedge clk) begin
      #4;
      if (!rst_n) begin
         exp_q.delete();
         m_key = 0;
         m_ok  = 0;
         m_err = 0;
      end else begin
         check_eq("ok_count", 32'(ok_count), 32'(m_ok));
         check_eq("err_count", 32'(err_count), 32'(m_err));
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_char(in_mode, int'(in_data), m_key));
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
            check_eq("pop_entry", 32'({out_err, out_data}), 32'(exp_v));
            if (exp_v[8]) m_err = (m_err == CMAX) ? CMAX : m_err + 1;
            else          m_ok  = (m_ok  == CMAX) ? CMAX : m_ok + 1;
         end
         if (key_load)
            m_key = (int'(key_in) >= P) ? int'(key_in) - P : int'(key_in);
         if (cnt_clr) begin
            m_ok  = 0;
            m_err = 0;
         end
      end
   end

   task automatic load_key(input logic [7:0] k);
      key_in = k;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
   endtask

   task automatic send(input logic [1:0] m, input logic [7:0] d);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("send_ready", 32'(in_ready), 32'd1);
      in_mode  = m;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Single character through an empty pipe with out_ready high.
   task automatic one(input string tag, input logic [1:0] m, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_e);
      send(m, d);
      check_eq({tag, "_lat_early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check_eq({tag, "_lat_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(out_data), 32'(exp_d));
      check_eq({tag, "_err"}, 32'(out_err), 32'(exp_e));
      @(negedge clk);
   endtask

   task automatic drain();
      int t = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_err", 32'(out_err), 32'd0);
      check_eq("rst_ok", 32'(ok_count), 32'd0);
      check_eq("rst_err", 32'(err_count), 32'd0);

      // Known-answer vectors
      load_key(8'h05);
      one("enc61_k05", 2'b10, 8'h61, 8'h5C, 1'b0);
      check_eq("ok_after_first", 32'(ok_count), 32'd1);
      load_key(8'h70);
      one("enc61_k70", 2'b10, 8'h61, 8'hD4, 1'b0);
      one("decD4_k70", 2'b01, 8'hD4, 8'h61, 1'b0);
      load_key(8'hF0);
      one("enc7A_k0D", 2'b10, 8'h7A, 8'h6D, 1'b0);

      // Error cases with a good character in between
      one("enc41_err", 2'b10, 8'h41, 8'h00, 1'b1);
      one("enc62_ok", 2'b10, 8'h62, 8'h55, 1'b0);
      one("decE5_err", 2'b01, 8'hE5, 8'h00, 1'b1);
      one("mode11_err", 2'b11, 8'h61, 8'h00, 1'b1);
      check_eq("err_count_3", 32'(err_count), 32'd3);
      check_eq("ok_count_5", 32'(ok_count), 32'd5);

      // Backpressure: exactly FIFO_DEPTH transfers
      out_ready = 1'b0;
      in_mode = 2'b10;
      acc_cnt = 0;
      in_valid = 1'b1;
      repeat (8) begin
         in_data = 8'($urandom_range(8'h7A, 8'h61));
         @(negedge clk);
      end
      check_eq("bp_transfers", 32'(acc_cnt), 32'd4);
      check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_in_ready_back", 32'(in_ready), 32'd1);
      check_eq("bp_still_valid", 32'(out_valid), 32'd1);
      drain();

      // Sustained throughput
      acc_cnt = 0;
      in_valid = 1'b1;
      repeat (12) begin
         in_data = 8'($urandom_range(8'h7A, 8'h61));
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_eq("tput_12", 32'(acc_cnt), 32'd12);
      drain();

      // key_load on the same edge as a transfer
      load_key(8'h0D);
      key_in = 8'h20;
      key_load = 1'b1;
      in_mode = 2'b10;
      in_data = 8'h61;
      in_valid = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("key_old_data", 32'(out_data), 32'h54);
      @(negedge clk);
      check_eq("key_new_data", 32'(out_data), 32'h41);
      drain();

      // Asynchronous reset with entries queued
      out_ready = 1'b0;
      in_valid = 1'b1;
      repeat (3) begin
         in_data = 8'($urandom_range(8'h7A, 8'h61));
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", 32'(out_valid), 32'd0);
      check_eq("arst_out_data", 32'(out_data), 32'd0);
      check_eq("arst_out_err", 32'(out_err), 32'd0);
      check_eq("arst_in_ready", 32'(in_ready), 32'd1);
      check_eq("arst_ok", 32'(ok_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_eq("post_rst_no_stale", 32'(out_valid), 32'd0);
      end

      // Saturation of a 4-bit counter, then clear colliding with a pop
      load_key(8'h03);
      in_mode = 2'b10;
      in_valid = 1'b1;
      repeat (17) begin
         in_data = 8'($urandom_range(8'h7A, 8'h61));
         @(negedge clk);
      end
      in_valid = 1'b0;
      drain();
      check_eq("ok_saturated", 32'(ok_count), 32'hF);
      send(2'b10, 8'h61);
      @(negedge clk);
      check_eq("clr_head_valid", 32'(out_valid), 32'd1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check_eq("clr_beats_pop", 32'(ok_count), 32'd0);

      // Randomised traffic
      repeat (400) begin
         int r;
         in_valid  = ($urandom % 3) != 0;
         r = int'($urandom % 8);
         if (r == 0)     in_mode = ($urandom % 2) ? 2'b11 : 2'b00;
         else if (r < 5) in_mode = 2'b10;
         else            in_mode = 2'b01;
         if (in_mode == 2'b10 && ($urandom % 4) != 0)
            in_data = 8'($urandom_range(8'h7A, 8'h61));
         else
            in_data = 8'($urandom);
         out_ready = ($urandom % 4) != 0;
         key_load  = ($urandom % 16) == 0;
         key_in    = 8'($urandom);
         cnt_clr   = ($urandom % 40) == 0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      key_load = 1'b0;
      cnt_clr  = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
